// File: rtl/k_means_stream.sv
// k_means_stream: buffers one frame of foreground pixels and runs Manhattan k-means over them.
// It emits the resulting centroids with a single-cycle valid strobe.
// Ports:
//   clk_in, rst_in (async, active-low).
//   x_in/y_in/pixel_valid_in/frame_end_in: pixel stream.
//   num_active_in, centroids_*_in: cluster count and seeds.
//   centroids_*_out, iter_count_out, converged_out, overflow_out: results.
//   valid_out: result strobe. busy_out: high whenever the block is not collecting.
module k_means_stream #(
    parameter int NUM_CLUSTERS = 7,
    parameter int X_WIDTH      = 9,
    parameter int Y_WIDTH      = 8,
    parameter int MAX_POINTS   = 1024,
    parameter int MAX_ITER     = 30,
    parameter int CONV_TOL     = 0
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [X_WIDTH-1:0]                  x_in,
    input  logic [Y_WIDTH-1:0]                  y_in,
    input  logic                                pixel_valid_in,
    input  logic                                frame_end_in,
    input  logic [$clog2(NUM_CLUSTERS+1)-1:0]   num_active_in,
    input  logic [NUM_CLUSTERS*X_WIDTH-1:0]     centroids_x_in,
    input  logic [NUM_CLUSTERS*Y_WIDTH-1:0]     centroids_y_in,
    output logic [NUM_CLUSTERS*X_WIDTH-1:0]     centroids_x_out,
    output logic [NUM_CLUSTERS*Y_WIDTH-1:0]     centroids_y_out,
    output logic                                valid_out,
    output logic                                busy_out,
    output logic [7:0]                          iter_count_out,
    output logic                                converged_out,
    output logic                                overflow_out
);
    localparam int NC  = NUM_CLUSTERS;
    localparam int XW  = X_WIDTH;
    localparam int YW  = Y_WIDTH;
    localparam int CW  = $clog2(NC + 1);
    localparam int PW  = $clog2(MAX_POINTS);
    localparam int NW  = PW + 1;
    localparam int MXW = (XW > YW) ? XW : YW;
    localparam int SW  = MXW + PW + 1;
    localparam int DW  = MXW + 1;
    localparam int BW  = $clog2(SW);

    typedef enum logic [2:0] {
        S_COLLECT, S_ASSIGN, S_DIVIDE, S_CHECK, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [NW-1:0] cnt_pts_q, cnt_pts_d, rd_idx_q, rd_idx_d;
    logic ovf_q, ovf_d, conv_q, conv_d;
    logic [CW-1:0] na_q, na_d, best_q, best_d, dc_q, dc_d;
    logic [XW-1:0] cx_q [NC];
    logic [XW-1:0] cx_d [NC];
    logic [YW-1:0] cy_q [NC];
    logic [YW-1:0] cy_d [NC];
    logic [7:0] iter_q, iter_d;
    logic v1_q, v1_d, v2_q, v2_d;
    logic [XW-1:0] p2x_q, p2x_d, nx_q, nx_d;
    logic [YW-1:0] p2y_q, p2y_d;
    logic [SW-1:0] sum_x_q [NC];
    logic [SW-1:0] sum_x_d [NC];
    logic [SW-1:0] sum_y_q [NC];
    logic [SW-1:0] sum_y_d [NC];
    logic [NW-1:0] ccnt_q [NC];
    logic [NW-1:0] ccnt_d [NC];
    logic dphase_q, dphase_d, dbusy_q, dbusy_d;
    logic [BW-1:0] dbit_q, dbit_d;
    logic [SW-1:0] dvd_q, dvd_d, rem_q, rem_d;
    logic [DW-1:0] mv_q, mv_d;
    logic [NC*XW-1:0] cxo_q, cxo_d;
    logic [NC*YW-1:0] cyo_q, cyo_d;
    logic [7:0] itero_q, itero_d;
    logic convo_q, convo_d, ovfo_q, ovfo_d, valid_q, valid_d;

    logic [XW-1:0] mem_x [MAX_POINTS];
    logic [YW-1:0] mem_y [MAX_POINTS];
    logic [XW-1:0] rd_x_q;
    logic [YW-1:0] rd_y_q;
    logic wr_en;

    logic [CW-1:0] na_clamp, best_idx;
    logic [DW-1:0] best_dist, cand_dist, mv_new;
    logic [SW:0] trial, dsr;
    logic take;
    logic [SW-1:0] rem_nx, quo_nx;

    function automatic logic [DW-1:0] mdist(
        input logic [XW-1:0] ax, input logic [XW-1:0] bx,
        input logic [YW-1:0] ay, input logic [YW-1:0] by
    );
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;
        dx = (ax >= bx) ? ax - bx : bx - ax;
        dy = (ay >= by) ? ay - by : by - ay;
        return DW'(dx) + DW'(dy);
    endfunction

    assign na_clamp = (num_active_in == '0) ? CW'(1) :
                      (num_active_in > CW'(NC)) ? CW'(NC) : num_active_in;

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_x[cnt_pts_q[PW-1:0]] <= x_in;
            mem_y[cnt_pts_q[PW-1:0]] <= y_in;
        end
        rd_x_q <= mem_x[rd_idx_q[PW-1:0]];
        rd_y_q <= mem_y[rd_idx_q[PW-1:0]];
    end

    // Nearest active centroid; strict compare keeps ties on the lowest slot.
    always_comb begin
        best_idx  = '0;
        best_dist = '1;
        cand_dist = '0;
        for (int i = 0; i < NC; i++) begin
            cand_dist = mdist(rd_x_q, cx_q[i], rd_y_q, cy_q[i]);
            if (CW'(i) < na_q && (i == 0 || cand_dist < best_dist)) begin
                best_idx  = CW'(i);
                best_dist = cand_dist;
            end
        end
    end

    // Restoring divider step; quotient bits shift into dvd from the bottom.
    always_comb begin
        trial  = {rem_q, dvd_q[SW-1]};
        dsr    = (SW+1)'(ccnt_q[dc_q]);
        take   = (trial >= dsr);
        rem_nx = take ? SW'(trial - dsr) : trial[SW-1:0];
        quo_nx = {dvd_q[SW-2:0], take};
        mv_new = mdist(nx_q, cx_q[dc_q], quo_nx[YW-1:0], cy_q[dc_q]);
    end

    always_comb begin
        state_d = state_q;   cnt_pts_d = cnt_pts_q; ovf_d = ovf_q;
        na_d = na_q;         cx_d = cx_q;           cy_d = cy_q;
        iter_d = iter_q;     conv_d = conv_q;       rd_idx_d = rd_idx_q;
        v1_d = 1'b0;         v2_d = 1'b0;           best_d = best_q;
        p2x_d = p2x_q;       p2y_d = p2y_q;
        sum_x_d = sum_x_q;   sum_y_d = sum_y_q;     ccnt_d = ccnt_q;
        dc_d = dc_q;         dphase_d = dphase_q;   dbusy_d = dbusy_q;
        dbit_d = dbit_q;     dvd_d = dvd_q;         rem_d = rem_q;
        nx_d = nx_q;         mv_d = mv_q;
        cxo_d = cxo_q;       cyo_d = cyo_q;         itero_d = itero_q;
        convo_d = convo_q;   ovfo_d = ovfo_q;       valid_d = 1'b0;
        wr_en = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (pixel_valid_in) begin
                    if (cnt_pts_q == NW'(MAX_POINTS)) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        cnt_pts_d = cnt_pts_q + NW'(1);
                    end
                end
                if (frame_end_in) begin
                    na_d     = na_clamp;
                    iter_d   = '0;
                    rd_idx_d = '0;
                    mv_d     = '0;
                    for (int i = 0; i < NC; i++) begin
                        cx_d[i]    = centroids_x_in[i*XW +: XW];
                        cy_d[i]    = centroids_y_in[i*YW +: YW];
                        sum_x_d[i] = '0;
                        sum_y_d[i] = '0;
                        ccnt_d[i]  = '0;
                    end
                    if (cnt_pts_d == '0) begin
                        state_d = S_DONE;
                        conv_d  = 1'b1;
                    end else begin
                        state_d = S_ASSIGN;
                    end
                end
            end
            S_ASSIGN: begin
                if (rd_idx_q != cnt_pts_q) begin
                    v1_d     = 1'b1;
                    rd_idx_d = rd_idx_q + NW'(1);
                end
                v2_d = v1_q;
                if (v1_q) begin
                    p2x_d  = rd_x_q;
                    p2y_d  = rd_y_q;
                    best_d = best_idx;
                end
                if (v2_q) begin
                    sum_x_d[best_q] = sum_x_q[best_q] + SW'(p2x_q);
                    sum_y_d[best_q] = sum_y_q[best_q] + SW'(p2y_q);
                    ccnt_d[best_q]  = ccnt_q[best_q] + NW'(1);
                end
                if (rd_idx_q == cnt_pts_q && !v1_q && !v2_q) begin
                    state_d  = S_DIVIDE;
                    dc_d     = '0;
                    dphase_d = 1'b0;
                    dbusy_d  = 1'b0;
                end
            end
            S_DIVIDE: begin
                if (!dbusy_q) begin
                    if (dc_q == na_q) begin
                        state_d = S_CHECK;
                    end else if (ccnt_q[dc_q] == '0) begin
                        dc_d = dc_q + CW'(1);
                    end else begin
                        dbusy_d = 1'b1;
                        dbit_d  = '0;
                        rem_d   = '0;
                        dvd_d   = dphase_q ? sum_y_q[dc_q] : sum_x_q[dc_q];
                    end
                end else begin
                    rem_d  = rem_nx;
                    dvd_d  = quo_nx;
                    dbit_d = dbit_q + BW'(1);
                    if (dbit_q == BW'(SW - 1)) begin
                        dbusy_d = 1'b0;
                        if (!dphase_q) begin
                            nx_d     = quo_nx[XW-1:0];
                            dphase_d = 1'b1;
                        end else begin
                            if (mv_new > mv_q) mv_d = mv_new;
                            cx_d[dc_q] = nx_q;
                            cy_d[dc_q] = quo_nx[YW-1:0];
                            dphase_d   = 1'b0;
                            dc_d       = dc_q + CW'(1);
                        end
                    end
                end
            end
            S_CHECK: begin
                iter_d = iter_q + 8'd1;
                for (int i = 0; i < NC; i++) begin
                    sum_x_d[i] = '0;
                    sum_y_d[i] = '0;
                    ccnt_d[i]  = '0;
                end
                if (mv_q <= DW'(CONV_TOL)) begin
                    state_d = S_DONE;
                    conv_d  = 1'b1;
                end else if (iter_d == 8'(MAX_ITER)) begin
                    state_d = S_DONE;
                    conv_d  = 1'b0;
                end else begin
                    state_d  = S_ASSIGN;
                    rd_idx_d = '0;
                    mv_d     = '0;
                end
            end
            S_DONE: begin
                for (int i = 0; i < NC; i++) begin
                    cxo_d[i*XW +: XW] = cx_q[i];
                    cyo_d[i*YW +: YW] = cy_q[i];
                end
                itero_d   = iter_q;
                convo_d   = conv_q;
                ovfo_d    = ovf_q;
                valid_d   = 1'b1;
                cnt_pts_d = '0;
                ovf_d     = 1'b0;
                state_d   = S_COLLECT;
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_COLLECT; cnt_pts_q <= '0; ovf_q <= 1'b0;
            na_q <= '0;   iter_q <= '0;   conv_q <= 1'b0;
            rd_idx_q <= '0; v1_q <= 1'b0; v2_q <= 1'b0;
            p2x_q <= '0;  p2y_q <= '0;    best_q <= '0;
            dc_q <= '0;   dphase_q <= 1'b0; dbusy_q <= 1'b0;
            dbit_q <= '0; dvd_q <= '0;    rem_q <= '0;
            nx_q <= '0;   mv_q <= '0;
            cxo_q <= '0;  cyo_q <= '0;    itero_q <= '0;
            convo_q <= 1'b0; ovfo_q <= 1'b0; valid_q <= 1'b0;
            for (int i = 0; i < NC; i++) begin
                cx_q[i] <= '0;    cy_q[i] <= '0;
                sum_x_q[i] <= '0; sum_y_q[i] <= '0;
                ccnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d; cnt_pts_q <= cnt_pts_d; ovf_q <= ovf_d;
            na_q <= na_d;   iter_q <= iter_d; conv_q <= conv_d;
            rd_idx_q <= rd_idx_d; v1_q <= v1_d; v2_q <= v2_d;
            p2x_q <= p2x_d; p2y_q <= p2y_d;   best_q <= best_d;
            dc_q <= dc_d;   dphase_q <= dphase_d; dbusy_q <= dbusy_d;
            dbit_q <= dbit_d; dvd_q <= dvd_d; rem_q <= rem_d;
            nx_q <= nx_d;   mv_q <= mv_d;
            cxo_q <= cxo_d; cyo_q <= cyo_d;   itero_q <= itero_d;
            convo_q <= convo_d; ovfo_q <= ovfo_d; valid_q <= valid_d;
            cx_q <= cx_d;   cy_q <= cy_d;
            sum_x_q <= sum_x_d; sum_y_q <= sum_y_d; ccnt_q <= ccnt_d;
        end
    end

    assign centroids_x_out = cxo_q;
    assign centroids_y_out = cyo_q;
    assign iter_count_out  = itero_q;
    assign converged_out   = convo_q;
    assign overflow_out    = ovfo_q;
    assign valid_out       = valid_q;
    assign busy_out        = (state_q != S_COLLECT);

endmodule

// File: tb/tb_k_means_stream.sv
// Bench for k_means_stream: three instances (default, 4-point buffer, 1-iteration cap).
// They share one stimulus stream and are each checked against a plain k-means model.
module tb_k_means_stream;
    localparam int NC = 7;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int LIMIT = 15000;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [XW-1:0] x_in = '0;
    logic [YW-1:0] y_in = '0;
    logic pixel_valid_in = 1'b0;
    logic frame_end_in = 1'b0;
    logic [2:0] num_active_in = '0;
    logic [NC*XW-1:0] centroids_x_in = '0;
    logic [NC*YW-1:0] centroids_y_in = '0;

    logic [NC*XW-1:0] cxo [3];
    logic [NC*YW-1:0] cyo [3];
    logic [7:0] ito [3];
    logic [2:0] vld, busy, cvo, ovo;

    int pulses [3] = '{0, 0, 0};
    int ncmp = 0;
    int nbad = 0;
    int mp_tab [3] = '{1024, 4, 1024};
    int mi_tab [3] = '{30, 30, 1};

    typedef struct {int x; int y;} pt_t;
    pt_t frame_q[$];
    int sx [NC];
    int sy [NC];

    k_means_stream u0 (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .pixel_valid_in(pixel_valid_in), .frame_end_in(frame_end_in),
        .num_active_in(num_active_in), .centroids_x_in(centroids_x_in),
        .centroids_y_in(centroids_y_in), .centroids_x_out(cxo[0]),
        .centroids_y_out(cyo[0]), .valid_out(vld[0]), .busy_out(busy[0]),
        .iter_count_out(ito[0]), .converged_out(cvo[0]), .overflow_out(ovo[0])
    );

    k_means_stream #(.MAX_POINTS(4)) u1 (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .pixel_valid_in(pixel_valid_in), .frame_end_in(frame_end_in),
        .num_active_in(num_active_in), .centroids_x_in(centroids_x_in),
        .centroids_y_in(centroids_y_in), .centroids_x_out(cxo[1]),
        .centroids_y_out(cyo[1]), .valid_out(vld[1]), .busy_out(busy[1]),
        .iter_count_out(ito[1]), .converged_out(cvo[1]), .overflow_out(ovo[1])
    );

    k_means_stream #(.MAX_ITER(1)) u2 (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .pixel_valid_in(pixel_valid_in), .frame_end_in(frame_end_in),
        .num_active_in(num_active_in), .centroids_x_in(centroids_x_in),
        .centroids_y_in(centroids_y_in), .centroids_x_out(cxo[2]),
        .centroids_y_out(cyo[2]), .valid_out(vld[2]), .busy_out(busy[2]),
        .iter_count_out(ito[2]), .converged_out(cvo[2]), .overflow_out(ovo[2])
    );

    always @(negedge clk_in) begin
        for (int k = 0; k < 3; k++) if (vld[k]) pulses[k] = pulses[k] + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Textbook k-means on the stored prefix of the frame.
    task automatic model(
        input int maxpts, input int maxiter, input int na_raw,
        output logic [NC*XW-1:0] ecx, output logic [NC*YW-1:0] ecy,
        output int eit, output int ecv, output int eov
    );
        int cx [NC];
        int cy [NC];
        int smx [NC];
        int smy [NC];
        int cnt [NC];
        int n, na, mv, best, bd, d, nxv, nyv, m;
        bit run;
        na = (na_raw < 1) ? 1 : ((na_raw > NC) ? NC : na_raw);
        n = (frame_q.size() > maxpts) ? maxpts : frame_q.size();
        eov = (frame_q.size() > maxpts) ? 1 : 0;
        for (int k = 0; k < NC; k++) begin
            cx[k] = sx[k];
            cy[k] = sy[k];
        end
        eit = 0;
        ecv = 1;
        run = (n > 0);
        while (run) begin
            for (int k = 0; k < NC; k++) begin
                smx[k] = 0; smy[k] = 0; cnt[k] = 0;
            end
            for (int p = 0; p < n; p++) begin
                best = 0;
                bd = iabs(frame_q[p].x - cx[0]) + iabs(frame_q[p].y - cy[0]);
                for (int k = 1; k < na; k++) begin
                    d = iabs(frame_q[p].x - cx[k]) + iabs(frame_q[p].y - cy[k]);
                    if (d < bd) begin
                        bd = d;
                        best = k;
                    end
                end
                smx[best] += frame_q[p].x;
                smy[best] += frame_q[p].y;
                cnt[best] += 1;
            end
            mv = 0;
            for (int k = 0; k < na; k++) begin
                if (cnt[k] > 0) begin
                    nxv = smx[k] / cnt[k];
                    nyv = smy[k] / cnt[k];
                    m = iabs(nxv - cx[k]) + iabs(nyv - cy[k]);
                    if (m > mv) mv = m;
                    cx[k] = nxv;
                    cy[k] = nyv;
                end
            end
            eit++;
            if (mv <= 0) begin
                ecv = 1;
                run = 0;
            end else if (eit == maxiter) begin
                ecv = 0;
                run = 0;
            end
        end
        ecx = '0;
        ecy = '0;
        for (int k = 0; k < NC; k++) begin
            ecx[k*XW +: XW] = XW'(cx[k]);
            ecy[k*YW +: YW] = YW'(cy[k]);
        end
    endtask

    task automatic rand_seeds();
        for (int k = 0; k < NC; k++) begin
            sx[k] = $urandom_range(0, 319);
            sy[k] = $urandom_range(0, 179);
        end
    endtask

    task automatic add_pt(input int x, input int y);
        pt_t p;
        p.x = x;
        p.y = y;
        frame_q.push_back(p);
    endtask

    task automatic run_frame(input int na_raw, input bit same, output int lat0);
        int start [3];
        logic [2:0] done;
        int cyc, eit, ecv, eov;
        logic [NC*XW-1:0] ecx;
        logic [NC*YW-1:0] ecy;
        for (int k = 0; k < 3; k++) start[k] = pulses[k];
        num_active_in = 3'(na_raw);
        for (int k = 0; k < NC; k++) begin
            centroids_x_in[k*XW +: XW] = XW'(sx[k]);
            centroids_y_in[k*YW +: YW] = YW'(sy[k]);
        end
        for (int i = 0; i < frame_q.size(); i++) begin
            x_in = XW'(frame_q[i].x);
            y_in = YW'(frame_q[i].y);
            pixel_valid_in = 1'b1;
            frame_end_in = same && (i == frame_q.size() - 1);
            @(negedge clk_in);
        end
        if (!same || frame_q.size() == 0) begin
            pixel_valid_in = 1'b0;
            frame_end_in = 1'b1;
            @(negedge clk_in);
        end
        pixel_valid_in = 1'b0;
        frame_end_in = 1'b0;
        done = '0;
        lat0 = -1;
        cyc = 0;
        while (done != 3'b111 && cyc < LIMIT) begin
            @(negedge clk_in);
            cyc++;
            done = done | vld;
            if (vld[0] && lat0 < 0) lat0 = cyc;
            pixel_valid_in = 1'b0;
            frame_end_in = 1'b0;
            // Junk pixels/frame ends while every instance is busy must be ignored.
            if (done != 3'b111 && busy == 3'b111 && $urandom_range(0, 3) == 0) begin
                x_in = XW'($urandom_range(0, 319));
                y_in = YW'($urandom_range(0, 179));
                pixel_valid_in = 1'b1;
                frame_end_in = 1'($urandom_range(0, 1));
            end
        end
        pixel_valid_in = 1'b0;
        frame_end_in = 1'b0;
        chk("done", done, 3'b111);
        repeat (3) @(negedge clk_in);
        for (int k = 0; k < 3; k++) begin
            model(mp_tab[k], mi_tab[k], na_raw, ecx, ecy, eit, ecv, eov);
            chk($sformatf("cx%0d", k), cxo[k], ecx);
            chk($sformatf("cy%0d", k), cyo[k], ecy);
            chk($sformatf("iter%0d", k), ito[k], eit);
            chk($sformatf("conv%0d", k), cvo[k], ecv);
            chk($sformatf("ovf%0d", k), ovo[k], eov);
            chk($sformatf("pulse%0d", k), pulses[k] - start[k], 1);
            chk($sformatf("idle%0d", k), busy[k], 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int st [3];
        repeat (3) @(negedge clk_in);
        chk("rst_cx", cxo[0], 0);
        chk("rst_cy", cyo[0], 0);
        chk("rst_valid", vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_iter", ito[0], 0);
        chk("rst_flags", {cvo[0], ovo[0]}, 0);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Two clusters
        rand_seeds();
        sx[0] = 0; sy[0] = 0; sx[1] = 300; sy[1] = 170;
        frame_q.delete();
        add_pt(10, 10); add_pt(12, 14); add_pt(290, 160); add_pt(294, 168);
        run_frame(2, 1'b0, lat);
        chk("two_c0", {cxo[0][8:0], cyo[0][7:0]}, {9'd11, 8'd12});
        chk("two_c1", {cxo[0][17:9], cyo[0][15:8]}, {9'd292, 8'd164});
        chk("two_it", {ito[0], cvo[0], ovo[0]}, {8'd2, 1'b1, 1'b0});
        chk("cap_c", {cxo[2][17:0], cyo[2][15:0]}, {9'd292, 9'd11, 8'd164, 8'd12});
        chk("cap_it", {ito[2], cvo[2]}, {8'd1, 1'b0});

        // Tie and empty cluster, last pixel together with frame end
        rand_seeds();
        sx[0] = 0; sy[0] = 0; sx[1] = 20; sy[1] = 0;
        frame_q.delete();
        add_pt(10, 0);
        run_frame(2, 1'b1, lat);
        chk("tie_c", {cxo[0][17:0], cyo[0][15:0]}, {9'd20, 9'd10, 8'd0, 8'd0});
        chk("tie_it", ito[0], 2);

        // Floor division
        rand_seeds();
        sx[0] = 5; sy[0] = 5;
        frame_q.delete();
        add_pt(0, 0); add_pt(1, 0);
        run_frame(1, 1'b0, lat);
        chk("floor_c", {cxo[0][8:0], cyo[0][7:0], cvo[0]}, {9'd0, 8'd0, 1'b1});

        // Overflow on the 4-point instance, then a clean follow-up
        rand_seeds();
        frame_q.delete();
        for (int i = 0; i < 6; i++) add_pt(40 * i + 3, 25 * i + 7);
        run_frame(2, 1'b0, lat);
        chk("ovf_small", ovo[1], 1);
        frame_q.delete();
        add_pt(100, 100); add_pt(200, 50);
        run_frame(2, 1'b0, lat);
        chk("ovf_clear", ovo[1], 0);

        // Zero points
        rand_seeds();
        frame_q.delete();
        run_frame(3, 1'b0, lat);
        chk("zero_lat", (lat >= 1 && lat <= 2), 1);

        // Randomised frames, including clamped cluster counts
        for (int f = 0; f < 5; f++) begin
            int np;
            rand_seeds();
            frame_q.delete();
            np = $urandom_range(0, 24);
            for (int i = 0; i < np; i++)
                add_pt($urandom_range(0, 319), $urandom_range(0, 179));
            run_frame($urandom_range(0, 7), 1'($urandom_range(0, 1)), lat);
        end

        // Reset in the middle of ASSIGN
        rand_seeds();
        frame_q.delete();
        for (int i = 0; i < 10; i++)
            add_pt($urandom_range(0, 319), $urandom_range(0, 179));
        for (int k = 0; k < 3; k++) st[k] = pulses[k];
        num_active_in = 3'd3;
        for (int i = 0; i < frame_q.size(); i++) begin
            x_in = XW'(frame_q[i].x);
            y_in = YW'(frame_q[i].y);
            pixel_valid_in = 1'b1;
            @(negedge clk_in);
        end
        pixel_valid_in = 1'b0;
        frame_end_in = 1'b1;
        @(negedge clk_in);
        frame_end_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("mid_busy", busy, 3'b111);
        #1 rst_in = 1'b0;
        #1;
        chk("mid_cx", cxo[0], 0);
        chk("mid_cy", cyo[0], 0);
        chk("mid_misc", {ito[0], cvo[0], ovo[0], vld}, 0);
        chk("mid_busy0", busy, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (300) @(negedge clk_in);
        chk("mid_nopulse", pulses[0] - st[0] + pulses[1] - st[1] + pulses[2] - st[2], 0);

        // Normal operation after the abort
        rand_seeds();
        frame_q.delete();
        for (int i = 0; i < 12; i++)
            add_pt($urandom_range(0, 319), $urandom_range(0, 179));
        run_frame(4, 1'b0, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
